// File: rtl/onehot_decode.sv
// 3-to-8 one-hot decoder with a programmable drive phase,
// a one-cycle gap and a saturating accepted-code counter.
module onehot_decode #(
  parameter int HOLDW = 4,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       in_code,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [HOLDW-1:0] hold_len,
  output logic [7:0]       out_onehot,
  output logic             out_valid,
  output logic [2:0]       last_code,
  output logic [CNTW-1:0]  evt_count
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GAP
  } state_e;

  state_e           state_q, state_d;
  logic [HOLDW-1:0] hold_q, hold_d;
  logic [2:0]       last_q, last_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [7:0]       oh_q, oh_d;
  logic             ov_q, ov_d;
  logic             accept;

  // Ready is gated by rst_n so nothing is offered while held in reset.
  assign in_ready = rst_n && (state_q == IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    oh_d    = oh_q;
    ov_d    = ov_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DRIVE;
          hold_d  = hold_len;
          last_d  = in_code;
          oh_d    = 8'h01 << in_code;
          ov_d    = 1'b1;
          if (cnt_q != {CNTW{1'b1}}) begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
      DRIVE: begin
        if (hold_q == '0) begin
          state_d = GAP;
          oh_d    = 8'h00;
          ov_d    = 1'b0;
        end else begin
          hold_d = hold_q - HOLDW'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        oh_d    = 8'h00;
        ov_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      last_q  <= 3'b000;
      cnt_q   <= '0;
      oh_q    <= 8'h00;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      oh_q    <= oh_d;
      ov_q    <= ov_d;
    end
  end

  assign out_onehot = oh_q;
  assign out_valid  = ov_q;
  assign last_code  = last_q;
  assign evt_count  = cnt_q;

endmodule

// File: tb/tb_onehot_decode.sv
// Randomized bench for onehot_decode against a timeline model;
// a second CNTW=2 instance exercises counter saturation.
module tb_onehot_decode;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] in_code;
  logic       in_valid;
  logic [3:0] hold_len;
  logic       in_ready, in_ready2;
  logic [7:0] out_onehot, out_onehot2;
  logic       out_valid, out_valid2;
  logic [2:0] last_code, last_code2;
  logic [7:0] evt_count;
  logic [1:0] evt_count2;

  always #5 clk = ~clk;

  onehot_decode #(.HOLDW(4), .CNTW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_code(in_code),
    .in_valid(in_valid), .in_ready(in_ready),
    .hold_len(hold_len), .out_onehot(out_onehot),
    .out_valid(out_valid), .last_code(last_code),
    .evt_count(evt_count)
  );

  onehot_decode #(.HOLDW(4), .CNTW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_code(in_code),
    .in_valid(in_valid), .in_ready(in_ready2),
    .hold_len(hold_len), .out_onehot(out_onehot2),
    .out_valid(out_valid2), .last_code(last_code2),
    .evt_count(evt_count2)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model: remember when the last accept happened and with which
  // parameters; everything else is arithmetic on elapsed cycles.
  int         t      = 0;
  bit         acc_ok = 0;
  int         acc_t  = 0;
  int         acc_h  = 0;
  logic [2:0] m_last = 3'd0;
  int         m_cnt  = 0;
  int         n_acc  = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
  endtask

  function automatic int elapsed();
    return t - acc_t - 1;
  endfunction

  function automatic bit m_idle();
    return !acc_ok || (elapsed() >= acc_h + 2);
  endfunction

  function automatic bit m_drive();
    return acc_ok && (elapsed() <= acc_h);
  endfunction

  function automatic logic [7:0] m_onehot();
    logic [7:0] one;
    one = 8'h01;
    return m_drive() ? (one << m_last) : 8'h00;
  endfunction

  task automatic step(logic v, logic [2:0] c, logic [3:0] h, logic r);
    bit rdy;
    in_valid = v;
    in_code  = c;
    hold_len = h;
    rst_n    = r;
    #1;
    rdy = r && m_idle();
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("in_ready2", 32'(in_ready2), 32'(rdy));
    @(posedge clk);
    if (!r) begin
      acc_ok = 0;
      m_last = 3'd0;
      m_cnt  = 0;
    end else if (v && rdy) begin
      acc_ok = 1;
      acc_t  = t;
      acc_h  = int'(h);
      m_last = c;
      m_cnt  = m_cnt + 1;
      n_acc++;
    end
    t++;
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_drive()));
    chk("out_onehot", 32'(out_onehot), 32'(m_onehot()));
    chk("last_code", 32'(last_code), 32'(m_last));
    chk("evt_count", 32'(evt_count), 32'(m_cnt > 255 ? 255 : m_cnt));
    chk("evt_count2", 32'(evt_count2), 32'(m_cnt > 3 ? 3 : m_cnt));
    chk("out_onehot2", 32'(out_onehot2), 32'(m_onehot()));
  endtask

  task automatic do_reset();
    step(0, 3'd0, 4'd0, 0);
    step(0, 3'd0, 4'd0, 0);
  endtask

  initial begin
    int a0;
    do_reset();
    chk("rst_cnt", 32'(evt_count), 32'd0);

    // Basic decode of code 5 with a single drive cycle.
    step(1, 3'd5, 4'd0, 1);
    chk("basic_oh", 32'(out_onehot), 32'h20);
    step(0, 3'd0, 4'd0, 1);
    chk("basic_gap", 32'(out_onehot), 32'h00);
    step(0, 3'd0, 4'd0, 1);
    chk("basic_cnt", 32'(evt_count), 32'd1);

    // Sweep all codes, hold_len=2, back to back.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      step(1, 3'(c), 4'd2, 1);
      for (int k = 0; k < 4; k++) step(0, 3'(c + 3), 4'd9, 1);
    end
    chk("sweep_cnt", 32'(evt_count), 32'd8);
    chk("sweep_last", 32'(last_code), 32'd7);

    // Continuous valid with hold_len=4 and a changing code.
    a0 = n_acc;
    for (int k = 0; k < 28; k++) begin
      step(1, 3'($urandom), 4'd4, 1);
    end
    chk("bp_accepts", 32'(n_acc - a0), 32'd4);

    // Reset asserted on the third drive cycle of a long hold.
    do_reset();
    step(1, 3'd6, 4'd15, 1);
    step(0, 3'd1, 4'd0, 1);
    step(0, 3'd2, 4'd0, 1);
    step(0, 3'd3, 4'd0, 0);
    chk("rst_mid_ov", 32'(out_valid), 32'd0);
    chk("rst_mid_cnt", 32'(evt_count), 32'd0);
    step(0, 3'd0, 4'd0, 1);

    // Five accepts to saturate the narrow counter.
    for (int i = 0; i < 5; i++) begin
      step(1, 3'(i + 2), 4'($urandom_range(0, 3)), 1);
      while (!m_idle()) step(0, 3'($urandom), 4'd0, 1);
    end
    chk("sat_cnt2", 32'(evt_count2), 32'd3);

    // Idle with toggling code.
    a0 = n_acc;
    for (int k = 0; k < 20; k++) step(0, 3'($urandom), 4'($urandom), 1);
    chk("idle_acc", 32'(n_acc - a0), 32'd0);

    // Random traffic with occasional reset.
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom), 3'($urandom), 4'($urandom),
           ($urandom_range(0, 39) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
